floo_route_hold: RTL and testbench

FLOO_ROUTE_HOLD -- requirements
Module: floo_route_hold

---
 rtl/floo_pkg.sv | 32 +++
 rtl/floo_route_hold.sv | 142 ++++++++++++++
 tb/tb_floo_route_hold.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared types for the FlooNoC route-hold stage: hold FSM states, XY/source
// route types and the routing configuration constants.
package floo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } hold_state_e;

    typedef enum logic [1:0] {
        SourceRouting = 2'd0,
        XYRouting     = 2'd1,
        IdTable       = 2'd2
    } route_algo_e;

    typedef struct packed {
        route_algo_e route_algo;
        logic        use_id_table;
    } route_cfg_t;

    localparam route_cfg_t RouteCfgDefault = '{route_algo: XYRouting, use_id_table: 1'b0};

    // Destination ID layout used when XY routing is selected.
    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] port_id;
    } xy_id_t;

    typedef logic [7:0] src_route_t;

endpackage

// File: rtl/floo_route_hold.sv
// Single-entry registered stage that latches the route of a packet header and
// replays it on every body flit. Define FLOO_ROUTE_HOLD_MCAST_EN to hold/forward mask_i.
module floo_route_hold
    import floo_pkg::*;
#(
    parameter type         id_t        = logic,
    parameter type         route_t     = logic,
    parameter type         payload_t   = logic,
    parameter int unsigned MaxBurstLen = 256
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     valid_i,
    output logic     ready_o,
    input  payload_t payload_i,
    input  logic     last_i,
    input  id_t      id_i,
    input  route_t   route_i,
    input  id_t      mask_i,
    output logic     valid_o,
    input  logic     ready_i,
    output payload_t payload_o,
    output logic     last_o,
    output id_t      dst_id_o,
    output route_t   route_o,
    output id_t      mask_o,
    output logic     busy_o,
    output logic     len_err_o
);

    localparam int unsigned CntW = $clog2(MaxBurstLen) + 1;
    localparam logic [CntW-1:0] LenLimit = CntW'(MaxBurstLen - 1);

    hold_state_e     state_reg, state_next;
    logic [CntW-1:0] beat_cnt_reg, beat_cnt_next;
    id_t             id_hold_reg;
    route_t          route_hold_reg;

    logic   accept;
    logic   is_header;
    logic   overlength;
    logic   last_eff;
    id_t    dst_id_sel;
    route_t route_sel;

    assign ready_o = !valid_o || ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an overlength flit closes the packet like a real last.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept && !last_eff) state_next = BURST;
            BURST:   if (accept && last_eff)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode for the current cycle
    always_comb begin
        accept     = valid_i && ready_o;
        is_header  = (state_reg == IDLE);
        overlength = accept && !last_i && (beat_cnt_reg == LenLimit);
        last_eff   = last_i || overlength;
        dst_id_sel = is_header ? id_i : id_hold_reg;
        route_sel  = is_header ? route_i : route_hold_reg;
    end

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        if (accept) begin
            if (state_next == IDLE) begin
                beat_cnt_next = '0;
            end else if (is_header) begin
                beat_cnt_next = CntW'(1);
            end else begin
                beat_cnt_next = beat_cnt_reg + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_reg   <= '0;
            id_hold_reg    <= '0;
            route_hold_reg <= '0;
            valid_o        <= 1'b0;
            payload_o      <= '0;
            last_o         <= 1'b0;
            dst_id_o       <= '0;
            route_o        <= '0;
            busy_o         <= 1'b0;
            len_err_o      <= 1'b0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            busy_o       <= (state_next == BURST);
            len_err_o    <= overlength;
            if (accept) begin
                if (is_header) begin
                    id_hold_reg    <= id_i;
                    route_hold_reg <= route_i;
                end
                valid_o   <= 1'b1;
                payload_o <= payload_i;
                last_o    <= last_eff;
                dst_id_o  <= dst_id_sel;
                route_o   <= route_sel;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifdef FLOO_ROUTE_HOLD_MCAST_EN
    id_t mask_hold_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_hold_reg <= '0;
            mask_o        <= '0;
        end else if (accept) begin
            if (is_header) begin
                mask_hold_reg <= mask_i;
            end
            mask_o <= is_header ? mask_i : mask_hold_reg;
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^{mask_i};
    assign mask_o      = '0;
`endif

endmodule

// File: tb/tb_floo_route_hold.sv
// Directed self-checking bench for floo_route_hold (MaxBurstLen=4, 8-bit IDs).
module tb_floo_route_hold;

    typedef logic [7:0]  id_t;
    typedef logic [7:0]  route_t;
    typedef logic [15:0] payload_t;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     valid_i, ready_o, last_i, valid_o, ready_i, last_o, busy_o, len_err_o;
    payload_t payload_i, payload_o;
    id_t      id_i, mask_i, dst_id_o, mask_o;
    route_t   route_i, route_o;

    int checks = 0;
    int errors = 0;

`ifdef FLOO_ROUTE_HOLD_MCAST_EN
    localparam logic [7:0] MaskExp = 8'h0F;
`else
    localparam logic [7:0] MaskExp = 8'h00;
`endif

    floo_route_hold #(
        .id_t(id_t), .route_t(route_t), .payload_t(payload_t), .MaxBurstLen(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .valid_i(valid_i), .ready_o(ready_o), .payload_i(payload_i), .last_i(last_i),
        .id_i(id_i), .route_i(route_i), .mask_i(mask_i),
        .valid_o(valid_o), .ready_i(ready_i), .payload_o(payload_o), .last_o(last_o),
        .dst_id_o(dst_id_o), .route_o(route_o), .mask_o(mask_o),
        .busy_o(busy_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [15:0] pl, input logic l,
                         input logic [7:0] id, input logic [7:0] rt, input logic [7:0] mk,
                         input logic rdy);
        valid_i = v; payload_i = pl; last_i = l; id_i = id; route_i = rt; mask_i = mk;
        ready_i = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick(); tick();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_lenerr", 32'(len_err_o), 32'd0);
        chk("rst_dst", 32'(dst_id_o), 32'h00);
        chk("rst_payload", 32'(payload_o), 32'h0000);
        rst_n = 1'b1;

        // Single-flit packet
        drive(1'b1, 16'hA001, 1'b1, 8'h12, 8'h01, 8'h00, 1'b1);
        tick();
        chk("sf_valid", 32'(valid_o), 32'd1);
        chk("sf_dst", 32'(dst_id_o), 32'h12);
        chk("sf_last", 32'(last_o), 32'd1);
        chk("sf_payload", 32'(payload_o), 32'hA001);
        chk("sf_busy", 32'(busy_o), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick();
        chk("sf_drain", 32'(valid_o), 32'd0);

        // 4-flit packet, body id_i changes but route is held
        drive(1'b1, 16'hB001, 1'b0, 8'h05, 8'h22, 8'h00, 1'b1);
        tick();
        chk("p4_f1_dst", 32'(dst_id_o), 32'h05);
        chk("p4_f1_busy", 32'(busy_o), 32'd1);
        drive(1'b1, 16'hB002, 1'b0, 8'h3F, 8'h99, 8'h00, 1'b1);
        tick();
        chk("p4_f2_dst", 32'(dst_id_o), 32'h05);
        chk("p4_f2_route", 32'(route_o), 32'h22);
        chk("p4_f2_busy", 32'(busy_o), 32'd1);
        drive(1'b1, 16'hB003, 1'b0, 8'h3F, 8'h99, 8'h00, 1'b1);
        tick();
        chk("p4_f3_dst", 32'(dst_id_o), 32'h05);
        chk("p4_f3_last", 32'(last_o), 32'd0);
        drive(1'b1, 16'hB004, 1'b1, 8'h3F, 8'h99, 8'h00, 1'b1);
        tick();
        chk("p4_f4_dst", 32'(dst_id_o), 32'h05);
        chk("p4_f4_last", 32'(last_o), 32'd1);
        chk("p4_f4_busy", 32'(busy_o), 32'd0);
        chk("p4_f4_lenerr", 32'(len_err_o), 32'd0);

        // Backpressure: output holds for 3 cycles, then streams without bubble
        drive(1'b1, 16'hC001, 1'b0, 8'h21, 8'h33, 8'h00, 1'b1);
        tick();
        drive(1'b1, 16'hC002, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b0);
        #1;
        chk("bp_ready", 32'(ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", 32'(valid_o), 32'd1);
            chk("bp_payload", 32'(payload_o), 32'hC001);
            chk("bp_dst", 32'(dst_id_o), 32'h21);
            chk("bp_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        #1;
        chk("bp_release", 32'(ready_o), 32'd1);
        tick();
        chk("st_payload2", 32'(payload_o), 32'hC002);
        chk("st_valid2", 32'(valid_o), 32'd1);
        chk("st_dst2", 32'(dst_id_o), 32'h21);
        drive(1'b1, 16'hC003, 1'b1, 8'h3F, 8'h00, 8'h00, 1'b1);
        tick();
        chk("st_payload3", 32'(payload_o), 32'hC003);
        chk("st_valid3", 32'(valid_o), 32'd1);
        chk("st_last3", 32'(last_o), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick();

        // Overlength: 5 non-last flits with MaxBurstLen=4
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(16'hD000 + i), 1'b0, (i == 1) ? 8'h44 : 8'h3F, 8'h00, 8'h00, 1'b1);
            tick();
            chk("ol_lenerr_lo", 32'(len_err_o), 32'd0);
            chk("ol_dst", 32'(dst_id_o), 32'h44);
        end
        drive(1'b1, 16'hD004, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b1);
        tick();
        chk("ol_f4_lenerr", 32'(len_err_o), 32'd1);
        chk("ol_f4_last", 32'(last_o), 32'd1);
        chk("ol_f4_busy", 32'(busy_o), 32'd0);
        drive(1'b1, 16'hD005, 1'b0, 8'h55, 8'h00, 8'h00, 1'b1);
        tick();
        chk("ol_f5_dst", 32'(dst_id_o), 32'h55);
        chk("ol_f5_lenerr", 32'(len_err_o), 32'd0);
        chk("ol_f5_busy", 32'(busy_o), 32'd1);
        chk("ol_f5_last", 32'(last_o), 32'd0);
        drive(1'b1, 16'hD006, 1'b1, 8'h3F, 8'h00, 8'h00, 1'b1);
        tick();
        chk("ol_end_busy", 32'(busy_o), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick();

        // Reset mid-packet
        drive(1'b1, 16'hE001, 1'b0, 8'h66, 8'h00, 8'h00, 1'b1);
        tick();
        drive(1'b1, 16'hE002, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b1);
        tick();
        chk("mr_busy_pre", 32'(busy_o), 32'd1);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(valid_o), 32'd0);
        chk("mr_busy", 32'(busy_o), 32'd0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 16'hE003, 1'b1, 8'h77, 8'h00, 8'h00, 1'b1);
        tick();
        chk("mr_hdr_dst", 32'(dst_id_o), 32'h77);
        chk("mr_hdr_last", 32'(last_o), 32'd1);
        chk("mr_hdr_busy", 32'(busy_o), 32'd0);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick();

        // Multicast mask: held from header when enabled, zero otherwise
        drive(1'b1, 16'hF001, 1'b0, 8'h10, 8'hA5, 8'h0F, 1'b1);
        tick();
        chk("mc_f1_mask", 32'(mask_o), 32'(MaskExp));
        drive(1'b1, 16'hF002, 1'b1, 8'h3F, 8'h11, 8'hF0, 1'b1);
        tick();
        chk("mc_f2_mask", 32'(mask_o), 32'(MaskExp));
        chk("mc_f2_route", 32'(route_o), 32'hA5);
        chk("mc_f2_dst", 32'(dst_id_o), 32'h10);
        drive(1'b0, 16'h0, 1'b0, 8'h0, 8'h0, 8'h0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
